// File: rtl/countdown_ctrl.sv
// countdown_ctrl: 6-digit BCD countdown timer with start/pause, clear,
// preset load in IDLE, blinking alarm in DONE and optional auto-clear.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   tick_1k    1 kHz single-cycle enable
//   key_start  start/pause toggle pulse
//   key_clear  abort/reload pulse (wins over key_start)
//   load_en    preset write strobe, honoured in IDLE only
//   load_val   new preset, BCD, digit 5 in [23:20]
//   digits     current count, BCD
//   running    state is RUN
//   done       state is DONE
//   alarm      blink signal, toggles in DONE only
//   blank      display blank request (done & ~alarm)
//
// state | meaning
// IDLE  | count shows preset, waiting for start or load
// RUN   | count decrements on tick_1k
// PAUSE | count held, ticks ignored
// DONE  | count at zero, alarm blinking, waiting for key or auto-clear
module countdown_ctrl #(
  parameter logic [23:0] PRESET      = 24'h060000,
  parameter int          BLINK_MS    = 500,
  parameter int          AUTO_CLR_MS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1k,
  input  logic        key_start,
  input  logic        key_clear,
  input  logic        load_en,
  input  logic [23:0] load_val,
  output logic [23:0] digits,
  output logic        running,
  output logic        done,
  output logic        alarm,
  output logic        blank
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  function automatic logic [23:0] bcd_clamp(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    for (int i = 0; i < 6; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple borrow through the digits; callers guarantee v != 0.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [23:0] PRESET_CLAMPED = bcd_clamp(PRESET);
  localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int AW = (AUTO_CLR_MS > 1) ? $clog2(AUTO_CLR_MS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
  localparam logic [AW-1:0] AUTO_LAST  = AW'(AUTO_CLR_MS - 1);

  state_t        state_q, state_d;
  logic [23:0]   preset_q, preset_d;
  logic [23:0]   count_q, count_d;
  logic          alarm_q, alarm_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      preset_q    <= PRESET_CLAMPED;
      count_q     <= PRESET_CLAMPED;
      alarm_q     <= 1'b0;
      blink_cnt_q <= '0;
      auto_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      preset_q    <= preset_d;
      count_q     <= count_d;
      alarm_q     <= alarm_d;
      blink_cnt_q <= blink_cnt_d;
      auto_cnt_q  <= auto_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    preset_d    = preset_q;
    count_d     = count_q;
    alarm_d     = alarm_q;
    blink_cnt_d = blink_cnt_q;
    auto_cnt_d  = auto_cnt_q;

    case (state_q)
      IDLE: begin
        if (key_clear) begin
          count_d = preset_q;
        end else if (key_start) begin
          if (count_q != 24'd0) begin
            state_d = RUN;
          end else begin
            state_d     = DONE;
            alarm_d     = 1'b1;
            blink_cnt_d = '0;
            auto_cnt_d  = '0;
          end
        end else if (load_en) begin
          preset_d = bcd_clamp(load_val);
          count_d  = bcd_clamp(load_val);
        end
      end

      RUN: begin
        if (key_clear) begin
          state_d = IDLE;
          count_d = preset_q;
        end else if (key_start) begin
          state_d = PAUSE;
        end else if (tick_1k || count_q == 24'd0) begin
          // Zero count in RUN is unreachable in practice; fall through to
          // DONE rather than wrap to 999999.
          if (count_q == 24'd1 || count_q == 24'd0) begin
            count_d     = 24'd0;
            state_d     = DONE;
            alarm_d     = 1'b1;
            blink_cnt_d = '0;
            auto_cnt_d  = '0;
          end else begin
            count_d = bcd_dec(count_q);
          end
        end
      end

      PAUSE: begin
        if (key_clear) begin
          state_d = IDLE;
          count_d = preset_q;
        end else if (key_start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        count_d = 24'd0;
        if (key_clear || key_start) begin
          state_d = IDLE;
          count_d = preset_q;
          alarm_d = 1'b0;
        end else if (tick_1k) begin
          if (AUTO_CLR_MS > 0 && auto_cnt_q == AUTO_LAST) begin
            state_d = IDLE;
            count_d = preset_q;
            alarm_d = 1'b0;
          end else begin
            if (AUTO_CLR_MS > 0) auto_cnt_d = auto_cnt_q + AW'(1);
            if (blink_cnt_q == BLINK_LAST) begin
              alarm_d     = ~alarm_q;
              blink_cnt_d = '0;
            end else begin
              blink_cnt_d = blink_cnt_q + BW'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = preset_q;
        alarm_d = 1'b0;
      end
    endcase
  end

  assign digits  = count_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign alarm   = alarm_q;
  assign blank   = done & ~alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Testbench for countdown_ctrl: directed scenarios followed by random key,
// tick and load traffic, all compared against a decimal-integer model.
module tb_countdown_ctrl;

  localparam int BLINK = 2;
  localparam int AUTO  = 5;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1k = 1'b0;
  logic        key_start = 1'b0;
  logic        key_clear = 1'b0;
  logic        load_en = 1'b0;
  logic [23:0] load_val = 24'd0;
  logic [23:0] digits;
  logic        running, done, alarm, blank;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .PRESET     (24'h060000),
    .BLINK_MS   (BLINK),
    .AUTO_CLR_MS(AUTO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1k  (tick_1k),
    .key_start(key_start),
    .key_clear(key_clear),
    .load_en  (load_en),
    .load_val (load_val),
    .digits   (digits),
    .running  (running),
    .done     (done),
    .alarm    (alarm),
    .blank    (blank)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model keeps the count as a plain decimal integer.
  int m_state, m_count, m_preset, m_dt;
  bit m_alarm;

  function automatic int clamp_val(input logic [23:0] v);
    int r = 0;
    int p = 1;
    for (int i = 0; i < 6; i++) begin
      logic [3:0] d;
      d = v[4*i +: 4];
      if (d > 4'd9) d = 4'd9;
      r += int'(d) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t /= 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state  = S_IDLE;
    m_preset = clamp_val(24'h060000);
    m_count  = m_preset;
    m_alarm  = 1'b0;
    m_dt     = 0;
  endtask

  task automatic model_enter_done();
    m_state = S_DONE;
    m_count = 0;
    m_alarm = 1'b1;
    m_dt    = 0;
  endtask

  task automatic model_to_idle();
    m_state = S_IDLE;
    m_count = m_preset;
    m_alarm = 1'b0;
  endtask

  task automatic model_step(input bit ks, input bit kc, input bit le,
                            input logic [23:0] lv, input bit tk);
    case (m_state)
      S_IDLE: begin
        if (kc) m_count = m_preset;
        else if (ks) begin
          if (m_count != 0) m_state = S_RUN;
          else model_enter_done();
        end else if (le) begin
          m_preset = clamp_val(lv);
          m_count  = m_preset;
        end
      end
      S_RUN: begin
        if (kc) model_to_idle();
        else if (ks) m_state = S_PAUSE;
        else if (tk) begin
          m_count -= 1;
          if (m_count == 0) model_enter_done();
        end
      end
      S_PAUSE: begin
        if (kc) model_to_idle();
        else if (ks) m_state = S_RUN;
      end
      default: begin
        if (kc || ks) model_to_idle();
        else if (tk) begin
          m_dt++;
          if (m_dt == AUTO) model_to_idle();
          else m_alarm = ((m_dt / BLINK) % 2) == 0;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    check("digits",  32'(digits),  32'(to_bcd(m_count)));
    check("running", 32'(running), 32'(m_state == S_RUN));
    check("done",    32'(done),    32'(m_state == S_DONE));
    check("alarm",   32'(alarm),   32'(m_alarm));
    check("blank",   32'(blank),   32'((m_state == S_DONE) && !m_alarm));
  endtask

  // Inputs are applied just after an edge, consumed at the next edge and
  // outputs sampled 1 ns later.
  task automatic step(input bit ks, input bit kc, input bit le,
                      input logic [23:0] lv, input bit tk);
    key_start = ks;
    key_clear = kc;
    load_en   = le;
    load_val  = lv;
    tick_1k   = tk;
    @(posedge clk);
    model_step(ks, kc, le, lv, tk);
    #1;
    key_start = 1'b0;
    key_clear = 1'b0;
    load_en   = 1'b0;
    tick_1k   = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_digits", 32'(digits), 32'h060000);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
  endtask

  task automatic tick();
    step(0, 0, 0, 24'd0, 1);
  endtask

  initial begin
    logic [23:0] lv;
    bit ks, kc, le, tk;
    bit exp_alarm [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    model_reset();
    #12;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();

    // Load 3, start, count down to DONE.
    step(0, 0, 1, 24'h000003, 0);
    check("load3", 32'(digits), 32'h000003);
    step(1, 0, 0, 24'd0, 0);
    check("start_run", 32'(running), 32'd1);
    tick(); check("cd2", 32'(digits), 32'h000002);
    tick(); check("cd1", 32'(digits), 32'h000001);
    tick(); check("cd0", 32'(digits), 32'h000000);
    check("cd_done", 32'(done), 32'd1);
    check("cd_running", 32'(running), 32'd0);
    check("done_entry_alarm", 32'(alarm), 32'd1);

    // Blink and auto-clear.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("blink_seq", 32'(alarm), 32'(exp_alarm[i]));
      check("blink_blank", 32'(blank), 32'(!exp_alarm[i]));
    end
    tick();
    check("auto_clr_done", 32'(done), 32'd0);
    check("auto_clr_digits", 32'(digits), 32'h000003);
    check("auto_clr_alarm", 32'(alarm), 32'd0);

    // Borrow across three digits.
    step(0, 0, 1, 24'h001000, 0);
    step(1, 0, 0, 24'd0, 0);
    tick();
    check("borrow", 32'(digits), 32'h000999);
    step(0, 1, 0, 24'd0, 0);

    // Pause wins over a simultaneous tick.
    step(0, 0, 1, 24'h000050, 0);
    step(1, 0, 0, 24'd0, 0);
    tick();
    step(1, 0, 0, 24'd0, 1);
    check("pause_hold", 32'(digits), 32'h000049);
    tick(); tick();
    check("pause_ticks", 32'(digits), 32'h000049);
    step(1, 0, 0, 24'd0, 0);
    tick();
    check("resume", 32'(digits), 32'h000048);

    // Clear beats start.
    step(1, 1, 0, 24'd0, 0);
    check("clr_win_digits", 32'(digits), 32'h000050);
    check("clr_win_running", 32'(running), 32'd0);

    // Clamp, and load ignored while running.
    step(0, 0, 1, 24'h0000A5, 0);
    check("clamp", 32'(digits), 32'h000095);
    step(1, 0, 0, 24'd0, 0);
    step(0, 0, 1, 24'h000007, 0);
    check("load_in_run", 32'(digits), 32'h000095);
    step(0, 1, 0, 24'd0, 0);
    check("preset_kept", 32'(digits), 32'h000095);

    // Start with zero count goes straight to DONE; start there returns.
    step(0, 0, 1, 24'h000000, 0);
    step(1, 0, 0, 24'd0, 0);
    check("zero_start_done", 32'(done), 32'd1);
    step(1, 0, 0, 24'd0, 0);
    check("done_start_idle", 32'(done), 32'd0);

    // Reset mid-DONE.
    step(0, 0, 1, 24'h000001, 0);
    step(1, 0, 0, 24'd0, 0);
    tick();
    check("pre_rst_done", 32'(done), 32'd1);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        ks = ($urandom_range(0, 99) < 6);
        kc = ($urandom_range(0, 99) < 3);
        le = ($urandom_range(0, 99) < 8);
        tk = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) lv = 24'($urandom);
        else lv = 24'($urandom) & 24'h0000FF;
        step(ks, kc, le, lv, tk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have parameter PRESET, default 24'h060000, power-up preset as 6 BCD digits (60.000 s at 1 ms resolution).
REQ-002 SHALL have parameter BLINK_MS, default 500, alarm half-period in tick_1k ticks.
REQ-003 SHALL have parameter AUTO_CLR_MS, default 0, ticks spent in DONE before auto-return to IDLE; 0 disables.
REQ-004 SHALL have port clk  in  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tick_1k  in  1  single-cycle enable at 1 kHz, synchronous to clk.
REQ-007 SHALL have port key_start  in  1  debounced single-cycle pulse: start/pause toggle.
REQ-008 SHALL have port key_clear  in  1  debounced single-cycle pulse: abort and reload preset.
REQ-009 SHALL have port load_en  in  1  single-cycle strobe: write load_val to preset.
REQ-010 SHALL have port load_val  in  24  new preset, BCD, digit i at [4i+3:4i], digit 5 most significant.
REQ-011 SHALL have port digits  out  24  current count, BCD, same packing as load_val; feeds the 6-digit display driver.
REQ-012 SHALL have port running  out  1  high while in RUN.
REQ-013 SHALL have port done  out  1  high while in DONE.
REQ-014 SHALL have port alarm  out  1  blink signal, toggles in DONE only.
REQ-015 SHALL have port blank  out  1  display blank request, equals done & ~alarm.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; outputs registered, no combinational key-to-output path except blank.
REQ-017 IDLE: digits = preset register; key_start with count != 0 -> RUN; key_start with count == 0 -> DONE.
REQ-018 RUN: each tick_1k decrements count by 1 in BCD (digit 0 -> 9 with borrow to next digit); tick with count == 000001 -> count 000000 and DONE the next cycle.
REQ-019 RUN: key_start -> PAUSE; if tick_1k is in the same cycle, key wins and no decrement occurs.
REQ-020 PAUSE: count held, ticks ignored; key_start -> RUN.
REQ-021 DONE: count held at 000000; key_start or key_clear -> IDLE with count reloaded from preset.
REQ-022 key_clear in RUN or PAUSE -> IDLE with count reloaded; key_clear and key_start in the same cycle: key_clear wins.
REQ-023 load_en is honoured only in IDLE: preset and count take load_val the next cycle; ignored in RUN, PAUSE and DONE.
REQ-024 Any load_val nibble > 9 SHALL be clamped to 9 on load.
REQ-025 Count SHALL never decrement below 000000 or wrap to 999999.
REQ-026 On DONE entry: alarm = 1, blink counter = 0; every BLINK_MS ticks alarm toggles; alarm forced to 0 on leaving DONE.
REQ-027 AUTO_CLR_MS > 0: after AUTO_CLR_MS ticks in DONE, go to IDLE with count reloaded, as for key_clear.
REQ-028 running and done SHALL reflect the current state in the same cycle the state register updates.

Reset
REQ-029 rst high SHALL immediately force: state IDLE, preset = PRESET (clamped per REQ-024), digits = PRESET, running = 0, done = 0, alarm = 0, blank = 0, blink and auto-clear counters = 0.
REQ-030 rst asserted mid-RUN or mid-DONE SHALL discard count and alarm phase; after release the block behaves as after power-up.

Verification
REQ-031 Reset, load_en with 24'h000003, key_start, 3 ticks -> digits 000002, 000001, 000000; done = 1 and running = 0 one cycle after the third tick.
REQ-032 Load 24'h001000, start, 1 tick -> digits 000999 (borrow across three digits).
REQ-033 In RUN, key_start and tick in the same cycle -> PAUSE, digits unchanged; further ticks leave digits unchanged; key_start resumes decrementing.
REQ-034 key_start and key_clear together in RUN -> IDLE, digits = preset, running = 0.
REQ-035 Load 24'h0000A5 -> digits 000095; load_en during RUN -> preset and digits unchanged.
REQ-036 BLINK_MS = 2, AUTO_CLR_MS = 5, reach DONE -> alarm 1,1,0,0,1 over ticks, blank = ~alarm; after the 5th tick -> IDLE, digits = preset, alarm = 0.
